// File: rtl/am_demodulation_pkg.sv
// Shared types, widths and helpers for the coherent AM demodulator.
// Optional feature macro: AM_DEMOD_SAT_EN (clamp output instead of wrapping).
package am_pkg;

  localparam int SAMPLE_W = 8;
  localparam int PROD_W   = 16;

  // Fill FSM: FILL until the boxcar window holds N fresh products, then RUN.
  typedef enum logic {
    FILL = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Clamp a wide signed value into the signed 8-bit sample range.
  function automatic logic signed [SAMPLE_W-1:0] sat_s8(input logic signed [31:0] x);
    logic signed [SAMPLE_W-1:0] r;
    if (x > 32'sd127) begin
      r = 8'sd127;
    end else if (x < -32'sd128) begin
      r = -8'sd128;
    end else begin
      r = x[SAMPLE_W-1:0];
    end
    return r;
  endfunction

endpackage

// File: rtl/am_demodulation_if.sv
// Sample/control bundle between the modulated-sample source and the demodulator.
// Handshake: in_valid qualifies am_in/cos_c for one cycle and out_valid qualifies
// demod_out for one cycle; there is no ready, the demodulator accepts every
// valid sample. clear is a level sampled on the clock and overrides in_valid.
interface am_demodulation_if;
  import am_pkg::*;

  logic                       clear;
  logic                       in_valid;
  logic signed [SAMPLE_W-1:0] am_in;
  logic signed [SAMPLE_W-1:0] cos_c;
  logic signed [SAMPLE_W-1:0] demod_out;
  logic                       out_valid;
  logic                       filled;
  state_t                     dbg_state;

  modport master (
    output clear, in_valid, am_in, cos_c,
    input  demod_out, out_valid, filled, dbg_state
  );

  modport slave (
    input  clear, in_valid, am_in, cos_c,
    output demod_out, out_valid, filled, dbg_state
  );
endinterface

// File: rtl/am_demodulation_boxcar.sv
// Power-of-two moving-sum filter: circular product buffer, write pointer,
// running sum and the FILL/RUN state machine. The buffer is not reset; its
// stale contents are ignored until the window has been refilled.
module am_boxcar
  import am_pkg::*;
#(
  parameter int LOG2_TAPS = 4
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 clear_i,
  input  logic                                 prod_valid_i,
  input  logic signed [PROD_W-1:0]             prod_i,
  output logic signed [PROD_W+LOG2_TAPS-1:0]   sum_o,
  output logic                                 upd_valid_o,
  output logic                                 filled_o,
  output state_t                               state_o
);

  localparam int N     = 1 << LOG2_TAPS;
  localparam int SUM_W = PROD_W + LOG2_TAPS;

  logic signed [PROD_W-1:0]  buf_mem [N];
  logic [LOG2_TAPS-1:0]      wptr_q;
  logic [LOG2_TAPS-1:0]      count_q;
  logic signed [SUM_W-1:0]   sum_q;
  logic signed [SUM_W-1:0]   sum_d;
  logic                      upd_valid_q;
  state_t                    state_q;

  logic signed [PROD_W-1:0]  old;
  logic signed [SUM_W-1:0]   prod_ext;
  logic signed [SUM_W-1:0]   old_ext;
  logic                      accept;

  assign accept   = prod_valid_i && !clear_i;
  // Stale buffer entries must not be subtracted while the window refills.
  assign old      = (state_q == RUN) ? buf_mem[wptr_q] : '0;
  assign prod_ext = {{LOG2_TAPS{prod_i[PROD_W-1]}}, prod_i};
  assign old_ext  = {{LOG2_TAPS{old[PROD_W-1]}}, old};
  assign sum_d    = sum_q + prod_ext - old_ext;

  // Product buffer write; no reset so it can map onto RAM.
  always_ff @(posedge clk) begin
    if (accept) begin
      buf_mem[wptr_q] <= prod_i;
    end
  end

  // Running sum, pointer, fill counter, FSM and update strobe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_q       <= '0;
      wptr_q      <= '0;
      count_q     <= '0;
      upd_valid_q <= 1'b0;
      state_q     <= FILL;
    end else if (clear_i) begin
      sum_q       <= '0;
      wptr_q      <= '0;
      count_q     <= '0;
      upd_valid_q <= 1'b0;
      state_q     <= FILL;
    end else if (prod_valid_i) begin
      sum_q  <= sum_d;
      wptr_q <= wptr_q + 1'b1;
      case (state_q)
        FILL: begin
          if (&count_q) begin
            // This product completes the window: it is the first output.
            state_q     <= RUN;
            count_q     <= '0;
            upd_valid_q <= 1'b1;
          end else begin
            count_q     <= count_q + 1'b1;
            upd_valid_q <= 1'b0;
          end
        end
        RUN: begin
          upd_valid_q <= 1'b1;
        end
        default: begin
          state_q     <= FILL;
          upd_valid_q <= 1'b0;
        end
      endcase
    end else begin
      upd_valid_q <= 1'b0;
    end
  end

  assign sum_o       = sum_q;
  assign upd_valid_o = upd_valid_q;
  assign filled_o    = (state_q == RUN);
  assign state_o     = state_q;

endmodule

// File: rtl/am_demodulation.sv
// Coherent AM demodulator: registered sample x carrier product, boxcar
// low-pass, arithmetic down-scaling and registered 8-bit output.
// Fixed 3-cycle latency, no backpressure.
// Optional feature macro: AM_DEMOD_SAT_EN (clamp scaled output to [-128,127];
// when undefined the low 8 bits are taken, wrapping).
module am_demodulation
  import am_pkg::*;
#(
  parameter int LOG2_TAPS = 4,
  parameter int OUT_SHIFT = 6
) (
  input  logic               clk,
  input  logic               rst,
  am_demodulation_if.slave   bus
);

  localparam int SUM_W = PROD_W + LOG2_TAPS;
  localparam int SHIFT = LOG2_TAPS + OUT_SHIFT;

  logic signed [PROD_W-1:0]   am_ext;
  logic signed [PROD_W-1:0]   cos_ext;
  logic signed [PROD_W-1:0]   prod_q;
  logic                       prod_valid_q;
  logic signed [SUM_W-1:0]    sum;
  logic                       upd_valid;
  logic signed [31:0]         sum_ext;
  logic signed [SAMPLE_W-1:0] scaled;
  logic signed [SAMPLE_W-1:0] demod_q;
  logic                       out_valid_q;

  assign am_ext  = {{(PROD_W-SAMPLE_W){bus.am_in[SAMPLE_W-1]}}, bus.am_in};
  assign cos_ext = {{(PROD_W-SAMPLE_W){bus.cos_c[SAMPLE_W-1]}}, bus.cos_c};

  // Stage 1: register the mixer product; clear discards the incoming sample.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prod_q       <= '0;
      prod_valid_q <= 1'b0;
    end else begin
      prod_valid_q <= bus.in_valid && !bus.clear;
      if (bus.in_valid) begin
        prod_q <= am_ext * cos_ext;
      end
    end
  end

  // Stage 2: moving-sum filter and fill FSM.
  am_boxcar #(
    .LOG2_TAPS (LOG2_TAPS)
  ) u_boxcar (
    .clk          (clk),
    .rst          (rst),
    .clear_i      (bus.clear),
    .prod_valid_i (prod_valid_q),
    .prod_i       (prod_q),
    .sum_o        (sum),
    .upd_valid_o  (upd_valid),
    .filled_o     (bus.filled),
    .state_o      (bus.dbg_state)
  );

  assign sum_ext = {{(32-SUM_W){sum[SUM_W-1]}}, sum};

  // Divide by N and apply the extra gain shift, then fit to 8 bits.
  always_comb begin
    scaled = '0;
`ifdef AM_DEMOD_SAT_EN
    scaled = sat_s8(sum_ext >>> SHIFT);
`else
    scaled = 8'(sum_ext >>> SHIFT);
`endif
  end

  // Stage 3: output register; demod_out holds between strobes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      demod_q     <= '0;
      out_valid_q <= 1'b0;
    end else if (bus.clear) begin
      out_valid_q <= 1'b0;
    end else begin
      out_valid_q <= upd_valid;
      if (upd_valid) begin
        demod_q <= scaled;
      end
    end
  end

  assign bus.demod_out = demod_q;
  assign bus.out_valid = out_valid_q;

endmodule
